// File: rtl/fuzz_top.sv
// fuzz_top: registered multi-function datapath for the rewiring fuzz harness.
// One 154-bit stimulus vector in, one 159-bit registered result vector out.
// Every output bit is driven straight from a flop; latency is one cycle.
module fuzz_top (
    input  logic         clk,
    input  logic         rst,
    input  logic [153:0] in_flat,
    output logic [158:0] out_flat
);

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } alu_op_e;

    // ---------------------------------------------------------------
    // Stimulus field decode
    // ---------------------------------------------------------------
    logic [31:0] a, b, c, d;
    alu_op_e     op;
    logic        acc_en, acc_clr;
    logic [4:0]  rot_amt;
    logic        rot_dir;
    logic        lfsr_load, lfsr_step;
    logic        cnt_en, cnt_load, cnt_dir;

    assign a         = in_flat[31:0];
    assign b         = in_flat[63:32];
    assign c         = in_flat[95:64];
    assign d         = in_flat[127:96];
    assign op        = alu_op_e'(in_flat[129:128]);
    assign acc_en    = in_flat[130];
    assign acc_clr   = in_flat[131];
    assign rot_amt   = in_flat[136:132];
    assign rot_dir   = in_flat[137];
    assign lfsr_load = in_flat[138];
    assign lfsr_step = in_flat[139];
    assign cnt_en    = in_flat[140];
    assign cnt_load  = in_flat[141];
    assign cnt_dir   = in_flat[142];

    // Reserved control bits are deliberately ignored.
    logic unused_reserved;
    assign unused_reserved = ^in_flat[153:143];

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic [31:0] alu_q, alu_d;
    logic        zero_q, zero_d;
    logic        carry_q, carry_d;
    logic [31:0] rot_q, rot_d;
    logic [5:0]  pop_q, pop_d;
    logic [5:0]  clz_q, clz_d;
    logic [31:0] acc_q, acc_d;
    logic        acc_ovf_q, acc_ovf_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [15:0] cnt_q, cnt_d;

    // ---------------------------------------------------------------
    // Combinational next-state
    // ---------------------------------------------------------------
    logic [32:0] alu_sum;
    logic [32:0] acc_sum;
    logic [63:0] rot_left, rot_right;

    assign alu_sum   = {1'b0, a} + {1'b0, b};
    assign acc_sum   = {1'b0, acc_q} + {1'b0, d};
    // Rotating a doubled copy turns a rotate into a plain shift; amt 0 passes c.
    assign rot_left  = {c, c} << rot_amt;
    assign rot_right = {c, c} >> rot_amt;

    // ALU result, carry/no-borrow flag and zero flag from the current operands
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        alu_d   = '0;
        carry_d = 1'b0;
        unique case (op)
            OP_ADD: begin
                alu_d   = alu_sum[31:0];
                carry_d = alu_sum[32];
            end
            OP_SUB: begin
                alu_d   = a - b;
                carry_d = (a >= b);
            end
            OP_AND: alu_d = a & b;
            OP_XOR: alu_d = a ^ b;
            default: alu_d = '0;
        endcase
        zero_d = (alu_d == 32'd0);
    end

    // Rotator output select by direction
    always_comb begin
        rot_d = rot_dir ? rot_right[31:0] : rot_left[63:32];
    end

    // Population count of d
    always_comb begin
        pop_d = '0;
        for (int i = 0; i < 32; i++) begin
            pop_d = pop_d + {5'b0, d[i]};
        end
    end

    // Leading-zero count of b; the highest set bit wins, b = 0 gives 32
    always_comb begin
        clz_d = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) begin
                clz_d = 6'(31 - i);
            end
        end
    end

    // Accumulator with sticky overflow; clear beats enable
    always_comb begin
        acc_d     = acc_q;
        acc_ovf_d = acc_ovf_q;
        if (acc_clr) begin
            acc_d     = '0;
            acc_ovf_d = 1'b0;
        end else if (acc_en) begin
            acc_d     = acc_sum[31:0];
            acc_ovf_d = acc_ovf_q | acc_sum[32];
        end
    end

    // Galois LFSR; load beats step and a zero seed is replaced so it never locks up
    always_comb begin
        lfsr_d = lfsr_q;
        if (lfsr_load) begin
            lfsr_d = (c == 32'd0) ? LFSR_SEED : c;
        end else if (lfsr_step) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 32'd0);
        end
    end

    // Up/down counter; load beats count
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_load) begin
            cnt_d = a[15:0];
        end else if (cnt_en) begin
            cnt_d = cnt_dir ? (cnt_q - 16'd1) : (cnt_q + 16'd1);
        end
    end

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------

    // Per-cycle result registers (no enables)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            alu_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            rot_q   <= '0;
            pop_q   <= '0;
            clz_q   <= '0;
        end else begin
            alu_q   <= alu_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            rot_q   <= rot_d;
            pop_q   <= pop_d;
            clz_q   <= clz_d;
        end
    end

    // Stateful units: accumulator, LFSR, counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            acc_ovf_q <= 1'b0;
            lfsr_q    <= LFSR_SEED;
            cnt_q     <= '0;
        end else begin
            acc_q     <= acc_d;
            acc_ovf_q <= acc_ovf_d;
            lfsr_q    <= lfsr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_flat = {clz_q, acc_ovf_q, carry_q, zero_q, pop_q,
                       cnt_q, lfsr_q, rot_q, acc_q, alu_q};

endmodule

// File: tb/tb_fuzz_top.sv
// tb_fuzz_top: directed-vector bench for fuzz_top with hand-computed results.
module tb_fuzz_top;

    logic         clk;
    logic         rst;
    logic [153:0] in_flat;
    logic [158:0] out_flat;

    int checks;
    int errors;

    // Control-field bit positions relative to ctrl[0] = in_flat[128]
    localparam logic [25:0] C_ADD    = 26'd0;
    localparam logic [25:0] C_SUB    = 26'd1;
    localparam logic [25:0] C_AND    = 26'd2;
    localparam logic [25:0] C_XOR    = 26'd3;
    localparam logic [25:0] C_ACC_EN = 26'd1 << 2;
    localparam logic [25:0] C_ACC_CL = 26'd1 << 3;
    localparam logic [25:0] C_ROT_R  = 26'd1 << 9;
    localparam logic [25:0] C_L_LOAD = 26'd1 << 10;
    localparam logic [25:0] C_L_STEP = 26'd1 << 11;
    localparam logic [25:0] C_CNT_EN = 26'd1 << 12;
    localparam logic [25:0] C_CNT_LD = 26'd1 << 13;
    localparam logic [25:0] C_CNT_DN = 26'd1 << 14;
    localparam logic [25:0] C_RSVD   = 26'h3FF_8000;

    localparam logic [158:0] RESET_VEC = 159'd1 << 96;

    fuzz_top dut (
        .clk      (clk),
        .rst      (rst),
        .in_flat  (in_flat),
        .out_flat (out_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field views of the result vector
    logic [31:0] o_alu, o_acc, o_rot, o_lfsr;
    logic [15:0] o_cnt;
    logic [5:0]  o_pop, o_clz;
    logic        o_zero, o_carry, o_ovf;
    assign o_alu   = out_flat[31:0];
    assign o_acc   = out_flat[63:32];
    assign o_rot   = out_flat[95:64];
    assign o_lfsr  = out_flat[127:96];
    assign o_cnt   = out_flat[143:128];
    assign o_pop   = out_flat[149:144];
    assign o_zero  = out_flat[150];
    assign o_carry = out_flat[151];
    assign o_ovf   = out_flat[152];
    assign o_clz   = out_flat[158:153];

    task automatic check(input string tag, input logic [158:0] obs, input logic [158:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [25:0] rot_amt(input int amt);
        return 26'(amt & 31) << 4;
    endfunction

    // Drive one vector, let one rising edge sample it, then settle past the edge
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] d, input logic [25:0] ctrl);
        in_flat = {ctrl, d, c, b, a};
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        in_flat = '0;
        #12;
        check("reset_vec", out_flat, RESET_VEC);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ALU add with carry out and zero result
        apply(32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, C_ADD);
        check("add_alu",   o_alu,   32'h0);
        check("add_zero",  o_zero,  1'b1);
        check("add_carry", o_carry, 1'b1);
        check("add_clz",   o_clz,   6'd31);

        // ALU sub with borrow
        apply(32'd3, 32'd5, 32'h0, 32'h0, C_SUB);
        check("sub_alu",   o_alu,   32'hFFFF_FFFE);
        check("sub_carry", o_carry, 1'b0);
        check("sub_zero",  o_zero,  1'b0);
        check("sub_clz",   o_clz,   6'd29);

        // Sub of equal operands: zero result, no borrow
        apply(32'd7, 32'd7, 32'h0, 32'h0, C_SUB);
        check("sub_eq_alu",   o_alu,   32'h0);
        check("sub_eq_carry", o_carry, 1'b1);
        check("sub_eq_zero",  o_zero,  1'b1);

        // Logic ops, carry forced low; b = 0 gives clz 32
        apply(32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'h0, C_AND);
        check("and_alu",   o_alu,   32'hF000_F000);
        check("and_carry", o_carry, 1'b0);
        check("and_clz",   o_clz,   6'd0);
        apply(32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'h0, C_XOR);
        check("xor_alu",   o_alu,   32'h0FF0_0FF0);
        apply(32'h0, 32'h0, 32'h0, 32'h0, C_XOR);
        check("clz_b0",    o_clz,   6'd32);
        check("xor_zero",  o_zero,  1'b1);

        // Accumulator: preload, wrap with overflow, sticky, clear wins
        apply(32'h0, 32'h1, 32'h0, 32'hFFFF_FFF0, C_ACC_EN);
        check("acc_pre",     o_acc, 32'hFFFF_FFF0);
        check("acc_pre_ovf", o_ovf, 1'b0);
        check("acc_pre_pop", o_pop, 6'd28);
        apply(32'h0, 32'h1, 32'h0, 32'h0000_0020, C_ACC_EN);
        check("acc_wrap",     o_acc, 32'h10);
        check("acc_wrap_ovf", o_ovf, 1'b1);
        check("acc_wrap_pop", o_pop, 6'd1);
        apply(32'h0, 32'h1, 32'h0, 32'h1, C_ACC_EN);
        check("acc_sticky",     o_acc, 32'h11);
        check("acc_sticky_ovf", o_ovf, 1'b1);
        apply(32'h0, 32'h1, 32'h0, 32'hFFFF_FFFF, 26'(C_ACC_EN | C_ACC_CL));
        check("acc_clr",     o_acc, 32'h0);
        check("acc_clr_ovf", o_ovf, 1'b0);
        check("pop_full",    o_pop, 6'd32);
        apply(32'h0, 32'h1, 32'h0, 32'h5, C_ADD);
        check("acc_hold", o_acc, 32'h0);

        // Rotator
        apply(32'h0, 32'h1, 32'h8000_0001, 32'h0, rot_amt(1));
        check("rot_l1", o_rot, 32'h0000_0003);
        apply(32'h0, 32'h1, 32'h8000_0001, 32'h0, 26'(rot_amt(1) | C_ROT_R));
        check("rot_r1", o_rot, 32'hC000_0000);
        apply(32'h0, 32'h1, 32'h8000_0001, 32'h0, rot_amt(31));
        check("rot_l31", o_rot, 32'hC000_0000);
        apply(32'h0, 32'h1, 32'h1234_5678, 32'h0, C_ROT_R);
        check("rot_0", o_rot, 32'h1234_5678);
        apply(32'h0, 32'h1, 32'h1234_5678, 32'h0, 26'(rot_amt(8) | C_ROT_R));
        check("rot_r8", o_rot, 32'h7812_3456);

        // LFSR: lfsr untouched since reset, so starts at 1
        apply(32'h0, 32'h1, 32'h0, 32'h0, C_L_STEP);
        check("lfsr_step1", o_lfsr, 32'h8020_0003);
        apply(32'h0, 32'h1, 32'h0, 32'h0, C_L_STEP);
        check("lfsr_step2", o_lfsr, 32'hC030_0002);
        apply(32'h0, 32'h1, 32'h0, 32'h0, C_L_LOAD);
        check("lfsr_load0", o_lfsr, 32'h0000_0001);
        apply(32'h0, 32'h1, 32'h1234_5678, 32'h0, 26'(C_L_LOAD | C_L_STEP));
        check("lfsr_load_wins", o_lfsr, 32'h1234_5678);
        apply(32'h0, 32'h1, 32'h0, 32'h0, C_L_STEP);
        check("lfsr_step_even", o_lfsr, 32'h091A_2B3C);

        // Counter: wrap both ways, load beats count
        apply(32'h0000_FFFF, 32'h1, 32'h0, 32'h0, C_CNT_LD);
        check("cnt_load", o_cnt, 16'hFFFF);
        apply(32'h0, 32'h1, 32'h0, 32'h0, C_CNT_EN);
        check("cnt_wrap_up", o_cnt, 16'h0000);
        apply(32'h0, 32'h1, 32'h0, 32'h0, 26'(C_CNT_EN | C_CNT_DN));
        check("cnt_wrap_dn", o_cnt, 16'hFFFF);
        apply(32'hABCD_1234, 32'h1, 32'h0, 32'h0, 26'(C_CNT_EN | C_CNT_LD));
        check("cnt_load_wins", o_cnt, 16'h1234);
        apply(32'h0, 32'h1, 32'h0, 32'h0, 26'(C_CNT_EN | C_CNT_DN));
        check("cnt_dn", o_cnt, 16'h1233);

        // Reserved bits set: whole vector must match the plain add result
        apply(32'h1, 32'h2, 32'h0, 32'h0000_000F, C_RSVD);
        check("rsvd_vec", out_flat,
              {6'd30, 1'b0, 1'b0, 1'b0, 6'd4, 16'h1233, 32'h091A_2B3C,
               32'h0, 32'h0, 32'h3});

        // Mid-run reset discards sticky overflow and all state
        apply(32'h0, 32'h1, 32'h0, 32'hFFFF_FFFF, C_ACC_EN);
        apply(32'h0, 32'h1, 32'h0, 32'h1, C_ACC_EN);
        check("ovf_before_rst", o_ovf, 1'b1);
        in_flat = '0;
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_vec", out_flat, RESET_VEC);
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(32'h0, 32'h1, 32'h0, 32'h0, C_CNT_EN);
        check("post_rst_cnt", o_cnt, 16'h0001);
        check("post_rst_ovf", o_ovf, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
